// File: rtl/ram_dc.sv
// RAM read-data decoder: selects one of eight RAM words or the IO64 input port
// from the CPU address and presents address and data on registered outputs.
module ram_dc (
    input  logic        CLK_DC,
    input  logic        RESET_N,
    input  logic [7:0]  RAM_AD_IN,
    input  logic [15:0] RAM_0,
    input  logic [15:0] RAM_1,
    input  logic [15:0] RAM_2,
    input  logic [15:0] RAM_3,
    input  logic [15:0] RAM_4,
    input  logic [15:0] RAM_5,
    input  logic [15:0] RAM_6,
    input  logic [15:0] RAM_7,
    input  logic [15:0] IO64_IN,
    output logic [7:0]  RAM_AD_OUT,
    output logic [15:0] RAM_OUT
);

    logic [15:0] rd_data_d;
    logic [15:0] rd_data_q;
    logic [7:0]  ram_ad_q;

    // Address decode: 0x00-0x07 pick a RAM word, 0x40-0x7F alias the IO port,
    // everything else reads as zero.
    always_comb begin
        rd_data_d = 16'h0000;
        if (RAM_AD_IN[7:3] == 5'b00000) begin
            case (RAM_AD_IN[2:0])
                3'd0: rd_data_d = RAM_0;
                3'd1: rd_data_d = RAM_1;
                3'd2: rd_data_d = RAM_2;
                3'd3: rd_data_d = RAM_3;
                3'd4: rd_data_d = RAM_4;
                3'd5: rd_data_d = RAM_5;
                3'd6: rd_data_d = RAM_6;
                3'd7: rd_data_d = RAM_7;
                default: rd_data_d = 16'h0000;
            endcase
        end else if (RAM_AD_IN[7:6] == 2'b01) begin
            rd_data_d = IO64_IN;
        end
    end

    // Output registers; reset clears both immediately, discarding any pending read.
    always_ff @(posedge CLK_DC or negedge RESET_N) begin
        if (!RESET_N) begin
            ram_ad_q  <= 8'h00;
            rd_data_q <= 16'h0000;
        end else begin
            ram_ad_q  <= RAM_AD_IN;
            rd_data_q <= rd_data_d;
        end
    end

    assign RAM_AD_OUT = ram_ad_q;
    assign RAM_OUT    = rd_data_q;

endmodule

// File: tb/tb_ram_dc.sv
// Self-checking bench for ram_dc: scoreboard of expected address/data pairs.
module tb_ram_dc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ad;
    logic [15:0] ram [8];
    logic [15:0] io;
    logic [7:0]  RAM_AD_OUT;
    logic [15:0] RAM_OUT;

    logic [7:0]  exp_ad_q   [$];
    logic [15:0] exp_data_q [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_dc dut (
        .CLK_DC     (clk),
        .RESET_N    (rst_n),
        .RAM_AD_IN  (ad),
        .RAM_0      (ram[0]),
        .RAM_1      (ram[1]),
        .RAM_2      (ram[2]),
        .RAM_3      (ram[3]),
        .RAM_4      (ram[4]),
        .RAM_5      (ram[5]),
        .RAM_6      (ram[6]),
        .RAM_7      (ram[7]),
        .IO64_IN    (io),
        .RAM_AD_OUT (RAM_AD_OUT),
        .RAM_OUT    (RAM_OUT)
    );

    // Reference decode of an address against the bench's current RAM/IO values.
    function automatic logic [15:0] model(input logic [7:0] a);
        if (a < 8'h08)                      return ram[a[2:0]];
        else if (a >= 8'h40 && a <= 8'h7F)  return io;
        else                                return 16'h0000;
    endfunction

    // Drive an address at the falling edge, record the expectation, then move
    // to just after the following rising edge.
    task automatic apply(input logic [7:0] a);
        @(negedge clk);
        ad = a;
        exp_ad_q.push_back(a);
        exp_data_q.push_back(model(a));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0]  ea;
        logic [15:0] ed;
        rst_n = 1'b0;
        ad    = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (RAM_AD_OUT !== 8'h00 || RAM_OUT !== 16'h0000) begin
                fails++;
                $display("FAIL reset_hold: got ad=%02h data=%04h, expected ad=00 data=0000",
                         RAM_AD_OUT, RAM_OUT);
            end
        end
        rst_n = 1'b1;
        apply(8'h03);
        ea = exp_ad_q.pop_front();
        ed = exp_data_q.pop_front();
        tests++;
        if (RAM_AD_OUT !== ea || RAM_OUT !== ed || ed !== 16'habcd) begin
            fails++;
            $display("FAIL reset_release: got ad=%02h data=%04h, expected ad=%02h data=abcd",
                     RAM_AD_OUT, RAM_OUT, ea);
        end
    endtask

    task automatic test_ram_sweep;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic [7:0]  prev_ad;
        logic [15:0] prev_data;
        for (int i = 0; i < 8; i++) begin
            prev_ad   = RAM_AD_OUT;
            prev_data = RAM_OUT;
            @(negedge clk);
            ad = 8'(i);
            exp_ad_q.push_back(8'(i));
            exp_data_q.push_back(model(8'(i)));
            #1;
            // new address must not show before the edge
            tests++;
            if (RAM_AD_OUT !== prev_ad || RAM_OUT !== prev_data) begin
                fails++;
                $display("FAIL sweep_latency addr=%02h: got ad=%02h data=%04h, expected ad=%02h data=%04h",
                         i, RAM_AD_OUT, RAM_OUT, prev_ad, prev_data);
            end
            @(posedge clk);
            #1;
            ea = exp_ad_q.pop_front();
            ed = exp_data_q.pop_front();
            tests++;
            if (RAM_AD_OUT !== ea || RAM_OUT !== ed) begin
                fails++;
                $display("FAIL sweep addr=%02h: got ad=%02h data=%04h, expected ad=%02h data=%04h",
                         i, RAM_AD_OUT, RAM_OUT, ea, ed);
            end
        end
    endtask

    task automatic test_io_port;
        logic [7:0]  addrs [3];
        logic [7:0]  ea;
        logic [15:0] ed;
        addrs = '{8'h40, 8'h41, 8'h7F};
        io = 16'h324f;
        for (int i = 0; i < 3; i++) begin
            apply(addrs[i]);
            ea = exp_ad_q.pop_front();
            ed = exp_data_q.pop_front();
            tests++;
            if (RAM_OUT !== ed || RAM_OUT !== 16'h324f) begin
                fails++;
                $display("FAIL io_data addr=%02h: got data=%04h, expected 324f",
                         addrs[i], RAM_OUT);
            end
            tests++;
            if (RAM_AD_OUT !== ea) begin
                fails++;
                $display("FAIL io_addr: got ad=%02h, expected ad=%02h", RAM_AD_OUT, ea);
            end
        end
    endtask

    task automatic test_unmapped;
        logic [7:0]  addrs [4];
        logic [7:0]  ea;
        logic [15:0] ed;
        addrs = '{8'h08, 8'h3F, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            apply(addrs[i]);
            ea = exp_ad_q.pop_front();
            ed = exp_data_q.pop_front();
            tests++;
            if (RAM_AD_OUT !== ea || RAM_OUT !== ed || ed !== 16'h0000) begin
                fails++;
                $display("FAIL unmapped addr=%02h: got ad=%02h data=%04h, expected ad=%02h data=0000",
                         addrs[i], RAM_AD_OUT, RAM_OUT, ea);
            end
        end
    endtask

    task automatic test_data_tracking;
        logic [7:0]  ea;
        logic [15:0] ed;
        apply(8'h02);
        ea = exp_ad_q.pop_front();
        ed = exp_data_q.pop_front();
        tests++;
        if (RAM_AD_OUT !== ea || RAM_OUT !== ed || ed !== 16'h7e6e) begin
            fails++;
            $display("FAIL track_before: got ad=%02h data=%04h, expected ad=02 data=7e6e",
                     RAM_AD_OUT, RAM_OUT);
        end
        @(negedge clk);
        ram[2] = 16'h1234;
        exp_ad_q.push_back(8'h02);
        exp_data_q.push_back(model(8'h02));
        #1;
        tests++;
        if (RAM_OUT !== 16'h7e6e) begin
            fails++;
            $display("FAIL track_hold: got data=%04h, expected 7e6e", RAM_OUT);
        end
        @(posedge clk);
        #1;
        ea = exp_ad_q.pop_front();
        ed = exp_data_q.pop_front();
        tests++;
        if (RAM_AD_OUT !== ea || RAM_OUT !== ed || ed !== 16'h1234) begin
            fails++;
            $display("FAIL track_after: got ad=%02h data=%04h, expected ad=02 data=1234",
                     RAM_AD_OUT, RAM_OUT);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0]  ea;
        logic [15:0] ed;
        apply(8'h03);
        ea = exp_ad_q.pop_front();
        ed = exp_data_q.pop_front();
        tests++;
        if (RAM_AD_OUT !== ea || RAM_OUT !== ed) begin
            fails++;
            $display("FAIL async_pre: got ad=%02h data=%04h, expected ad=%02h data=%04h",
                     RAM_AD_OUT, RAM_OUT, ea, ed);
        end
        // mid-cycle: well away from either clock edge
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (RAM_AD_OUT !== 8'h00 || RAM_OUT !== 16'h0000) begin
            fails++;
            $display("FAIL async_immediate: got ad=%02h data=%04h, expected ad=00 data=0000",
                     RAM_AD_OUT, RAM_OUT);
        end
        @(posedge clk);
        #1;
        tests++;
        if (RAM_AD_OUT !== 8'h00 || RAM_OUT !== 16'h0000) begin
            fails++;
            $display("FAIL async_held: got ad=%02h data=%04h, expected ad=00 data=0000",
                     RAM_AD_OUT, RAM_OUT);
        end
        rst_n = 1'b1;
        apply(8'h07);
        ea = exp_ad_q.pop_front();
        ed = exp_data_q.pop_front();
        tests++;
        if (RAM_AD_OUT !== ea || RAM_OUT !== ed || ed !== 16'h808d) begin
            fails++;
            $display("FAIL async_recover: got ad=%02h data=%04h, expected ad=07 data=808d",
                     RAM_AD_OUT, RAM_OUT);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ad     = 8'h03;
        io     = 16'h0000;
        ram[0] = 16'h6535;
        ram[1] = 16'h7628;
        ram[2] = 16'h7e6e;
        ram[3] = 16'habcd;
        ram[4] = 16'h64a6;
        ram[5] = 16'h0000;
        ram[6] = 16'h34b1;
        ram[7] = 16'h808d;

        test_reset();
        test_ram_sweep();
        test_io_port();
        test_unmapped();
        test_data_tracking();
        ram[2] = 16'h7e6e;
        test_async_reset();

        tests++;
        if (exp_ad_q.size() != 0 || exp_data_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_ad_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
